// File: rtl/ecc_mem_ctrl.sv
// ecc_mem_ctrl: request sequencer for a Hamming(7,4)-protected register array.
// Writes are encoded into 7-bit codewords. Reads are checked and corrected, and
// every corrected codeword is written back. A fault-injection port XORs a mask
// into a stored codeword.
// Optional background scrubber: define ECC_SCRUB_EN.
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// The requester holds req_we/req_addr/req_wdata stable while req_valid is high.
// rsp_valid is a one-cycle strobe with no back-pressure.
module ecc_mem_ctrl #(
  parameter int ADDR_W         = 4,
  parameter int SCRUB_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_wdata,
  output logic              rsp_valid,
  output logic [3:0]        rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        rsp_syndrome,
  input  logic              inj_valid,
  input  logic [ADDR_W-1:0] inj_addr,
  input  logic [6:0]        inj_mask,
  output logic [7:0]        err_count,
  output logic              scrub_active
);

  localparam int DEPTH = 2 ** ADDR_W;

`ifdef ECC_SCRUB_EN
  typedef enum logic [2:0] {IDLE, CHK, WB, SCRUB_CHK, SCRUB_WB} state_t;
  localparam int TW = $clog2(SCRUB_INTERVAL);
  localparam logic [TW-1:0] TMAX = TW'(SCRUB_INTERVAL - 1);
  logic [TW-1:0]     timer_q;
  logic [ADDR_W-1:0] scrub_addr_q;
`else
  typedef enum logic [1:0] {IDLE, CHK, WB} state_t;
`endif

  state_t            state_q, state_d;
  logic [6:0]        mem_q [DEPTH];
  logic [6:0]        cw_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [3:0]        rsp_rdata_q;
  logic [2:0]        rsp_syn_q;
  logic [7:0]        err_cnt_q;

  logic [2:0]        syn;
  logic [6:0]        fixed;
  logic              in_chk, rd_go, scrub_go, wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [6:0]        wr_data;

  function automatic logic [6:0] encode(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  // Syndrome and single-bit correction of the latched codeword.
  always_comb begin
    syn = {cw_q[3] ^ cw_q[4] ^ cw_q[5] ^ cw_q[6],
           cw_q[1] ^ cw_q[2] ^ cw_q[5] ^ cw_q[6],
           cw_q[0] ^ cw_q[2] ^ cw_q[4] ^ cw_q[6]};
    fixed = cw_q;
    if (syn != 3'd0) fixed = cw_q ^ (7'd1 << (syn - 3'd1));
`ifdef ECC_SCRUB_EN
    in_chk = (state_q == CHK) || (state_q == SCRUB_CHK);
`else
    in_chk = (state_q == CHK);
`endif
  end

  // Next-state logic, handshake and array write port selection.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rd_go     = 1'b0;
    scrub_go  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = req_addr;
    wr_data   = encode(req_wdata);
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_we) begin
            wr_en = 1'b1;
          end else begin
            rd_go   = 1'b1;
            state_d = CHK;
          end
        end
`ifdef ECC_SCRUB_EN
        else if (timer_q == TMAX) begin
          scrub_go = 1'b1;
          state_d  = SCRUB_CHK;
        end
`endif
      end
      CHK: state_d = (syn != 3'd0) ? WB : IDLE;
      WB: begin
        wr_en   = 1'b1;
        wr_addr = addr_q;
        wr_data = cw_q;
        state_d = IDLE;
      end
`ifdef ECC_SCRUB_EN
      SCRUB_CHK: state_d = (syn != 3'd0) ? SCRUB_WB : IDLE;
      SCRUB_WB: begin
        wr_en   = 1'b1;
        wr_addr = addr_q;
        wr_data = cw_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, array, latched codeword, response registers and error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cw_q        <= 7'h00;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 4'h0;
      rsp_err_q   <= 1'b0;
      rsp_syn_q   <= 3'd0;
      err_cnt_q   <= 8'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 7'h00;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      if (rd_go) begin
        cw_q   <= mem_q[req_addr];
        addr_q <= req_addr;
      end
`ifdef ECC_SCRUB_EN
      if (scrub_go) begin
        cw_q   <= mem_q[scrub_addr_q];
        addr_q <= scrub_addr_q;
      end
`endif
      if (in_chk) begin
        cw_q <= fixed;
        if (syn != 3'd0 && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
      if (state_q == CHK) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= {fixed[6], fixed[5], fixed[4], fixed[2]};
        rsp_err_q   <= (syn != 3'd0);
        rsp_syn_q   <= syn;
      end
      // An array write in the same cycle takes priority over an injection.
      if (wr_en) mem_q[wr_addr] <= wr_data;
      else if (inj_valid) mem_q[inj_addr] <= mem_q[inj_addr] ^ inj_mask;
    end
  end

`ifdef ECC_SCRUB_EN
  // Scrub timer counts idle cycles without traffic; scrub address walks the array.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q      <= '0;
      scrub_addr_q <= '0;
    end else begin
      if (state_q == IDLE && !req_valid) timer_q <= (timer_q == TMAX) ? '0 : timer_q + 1'b1;
      if ((state_q == SCRUB_CHK && syn == 3'd0) || state_q == SCRUB_WB)
        scrub_addr_q <= scrub_addr_q + 1'b1;
    end
  end
  assign scrub_active = (state_q == SCRUB_CHK) || (state_q == SCRUB_WB);
`else
  logic unused_interval;
  assign unused_interval = (SCRUB_INTERVAL > 1);
  assign scrub_active    = 1'b0;
`endif

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_err      = rsp_err_q;
  assign rsp_syndrome = rsp_syn_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_ecc_mem_ctrl.sv
// Bench for ecc_mem_ctrl: Hamming-position model of the array, expected-response
// queue checked on every rsp_valid, plus hand-computed literal expectations.
module tb_ecc_mem_ctrl;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
`ifdef ECC_SCRUB_EN
  localparam int SCRUB_ERRS = 1;
`else
  localparam int SCRUB_ERRS = 0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [3:0]        req_wdata = 4'h0;
  logic              rsp_valid;
  logic [3:0]        rsp_rdata;
  logic              rsp_err;
  logic [2:0]        rsp_syndrome;
  logic              inj_valid = 1'b0;
  logic [ADDR_W-1:0] inj_addr = '0;
  logic [6:0]        inj_mask = 7'h00;
  logic [7:0]        err_count;
  logic              scrub_active;

  ecc_mem_ctrl #(.ADDR_W(ADDR_W), .SCRUB_INTERVAL(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_syndrome(rsp_syndrome), .inj_valid(inj_valid), .inj_addr(inj_addr),
    .inj_mask(inj_mask), .err_count(err_count), .scrub_active(scrub_active)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: stored codeword = encode(mdl_data) ^ mdl_err
  logic [3:0]  mdl_data [DEPTH];
  logic [6:0]  mdl_err  [DEPTH];
  int          mdl_cnt;
  logic [15:0] exp_q[$];   // {err_count, rdata, err, syndrome}
  logic [15:0] cmp_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Syndrome as XOR of 1-based positions of set bits.
  function automatic logic [2:0] m_syn(input logic [6:0] cw);
    logic [2:0] s = 3'd0;
    for (int i = 0; i < 7; i++) if (cw[i]) s ^= 3'(i + 1);
    return s;
  endfunction

  // Data at positions 3,5,6,7; parity at positions 1,2,4 zeroes the syndrome.
  function automatic logic [6:0] m_enc(input logic [3:0] d);
    logic [6:0] cw = 7'h00;
    logic [2:0] s;
    cw[2] = d[0]; cw[4] = d[1]; cw[5] = d[2]; cw[6] = d[3];
    s = m_syn(cw);
    cw[0] = s[0]; cw[1] = s[1]; cw[3] = s[2];
    return cw;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_data[i] = 4'h0;
      mdl_err[i]  = 7'h00;
    end
    mdl_cnt = 0;
    exp_q.delete();
  endtask

  // Scoreboard: every response strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_spurious", 32'(exp_q.size()), 1);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, cmp_e[7:4]);
        chk("rsp_err", rsp_err, cmp_e[3]);
        chk("rsp_syndrome", rsp_syndrome, cmp_e[2:0]);
        chk("err_count", err_count, cmp_e[15:8]);
      end
    end
  end

  // Driver tasks: all start and end on a falling edge.
  task automatic wait_ready(input string nm);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(nm, req_ready, 1);
  endtask

  task automatic do_write(input int a, input logic [3:0] d);
    wait_ready("wr_ready_wait");
    req_valid = 1'b1; req_we = 1'b1; req_addr = ADDR_W'(a); req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    chk("wr_ready_stay", req_ready, 1);
    mdl_data[a] = d;
    mdl_err[a]  = 7'h00;
  endtask

  task automatic do_inject(input int a, input logic [6:0] m);
    inj_valid = 1'b1; inj_addr = ADDR_W'(a); inj_mask = m;
    @(negedge clk);
    inj_valid = 1'b0;
    mdl_err[a] ^= m;
  endtask

  task automatic do_read(input int a);
    logic [6:0] cw;
    logic [2:0] s;
    logic [3:0] d;
    logic       hit;
    wait_ready("rd_ready_wait");
    cw = m_enc(mdl_data[a]) ^ mdl_err[a];
    s  = m_syn(cw);
    if (s != 3'd0) cw[int'(s) - 1] = ~cw[int'(s) - 1];
    d   = {cw[6], cw[5], cw[4], cw[2]};
    hit = (s != 3'd0);
    if (hit && mdl_cnt < 255) mdl_cnt++;
    mdl_data[a] = d;
    mdl_err[a]  = 7'h00;
    exp_q.push_back({8'(mdl_cnt), d, hit, s});
    req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_W'(a);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_rsp_early", rsp_valid, 0);
    chk("rd_ready_chk", req_ready, 0);
    @(negedge clk);
    chk("rd_rsp_strobe", rsp_valid, 1);
    chk("rd_ready_wb", req_ready, 32'(!hit));
    if (hit) begin
      @(negedge clk);
      chk("rd_ready_back", req_ready, 1);
      chk("rd_rsp_once", rsp_valid, 0);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    apply_reset();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_syn", rsp_syndrome, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_scrub_active", scrub_active, 0);

`ifdef ECC_SCRUB_EN
    begin
      int n = 0;
      logic seen = 1'b0;
      do_inject(0, 7'h04);
      while (err_count != 8'd1 && n < 10) begin
        @(negedge clk);
        if (scrub_active) seen = 1'b1;
        n++;
      end
      chk("scrub_err_count", err_count, 1);
      chk("scrub_active_seen", seen, 1);
      mdl_err[0] = 7'h00;
      mdl_cnt    = 1;
      do_read(0);
      chk("scrub_reread_err", rsp_err, 0);
    end
`endif

    // Write then read, clean codeword
    chk("model_enc_b", m_enc(4'hB), 7'h55);
    do_write(3, 4'hB);
    do_read(3);
    chk("lit_rdata_b", rsp_rdata, 4'hB);
    chk("lit_syn_clean", rsp_syndrome, 0);
    chk("lit_cnt_clean", err_count, SCRUB_ERRS);

    // Single-bit error on cw4, corrected and written back
    do_inject(3, 7'h10);
    do_read(3);
    chk("lit_rdata_fix", rsp_rdata, 4'hB);
    chk("lit_err_fix", rsp_err, 1);
    chk("lit_syn_5", rsp_syndrome, 3'd5);
    chk("lit_cnt_fix", err_count, SCRUB_ERRS + 1);
    do_read(3);
    chk("lit_reread_err", rsp_err, 0);

    // Several patterns, back-to-back reads
    do_write(1, 4'h1);
    do_write(2, 4'h7);
    do_write(7, 4'hE);
    do_write(15, 4'hF);
    do_write(5, 4'h6);
    do_read(1);
    do_read(2);
    do_read(7);
    do_read(15);

    // Parity bit cw0 on the all-zero word at address 0
    do_inject(0, 7'h01);
    do_read(0);
    chk("lit_rdata_zero", rsp_rdata, 0);
    chk("lit_syn_1", rsp_syndrome, 3'd1);

    // Double error is miscorrected: data 6 becomes 7
    do_inject(5, 7'h03);
    do_read(5);
    chk("lit_rdata_dbl", rsp_rdata, 4'h7);
    chk("lit_syn_3", rsp_syndrome, 3'd3);
    do_read(5);

    // Top bit of the codeword at the last address
    do_inject(15, 7'h40);
    do_read(15);
    chk("lit_syn_7", rsp_syndrome, 3'd7);
    chk("lit_rdata_f", rsp_rdata, 4'hF);

    // Reset one cycle after a read accept drops the response
    wait_ready("rst_ready_wait");
    req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_rsp", rsp_valid, 0);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    chk("rst_drop_rsp2", rsp_valid, 0);
    do_read(3);
    chk("lit_rdata_cleared", rsp_rdata, 0);
    chk("lit_cnt_cleared", err_count, 0);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      do_inject(i % DEPTH, 7'(1 << (i % 7)));
      do_read(i % DEPTH);
    end
    chk("lit_cnt_sat", err_count, 255);

    repeat (3) @(negedge clk);
    chk("rsp_missing", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ecc_mem_ctrl.md
# ecc_mem_ctrl

Sequencing controller for a small Hamming(7,4)-protected register memory. It accepts 4-bit read/write requests over a valid/ready handshake, encodes writes into 7-bit codewords, and checks and corrects read codewords. Every corrected codeword is written back to the array. An optional background scrubber walks the array, and a fault-injection port corrupts stored codewords for test.

## Interface
- ADDR_W, 4, address width; array depth is 2**ADDR_W codewords
- SCRUB_INTERVAL, 64, idle cycles between scrub operations (≥2)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  4  write data
- rsp_valid  out  1  one-cycle read-response strobe
- rsp_rdata  out  4  corrected read data
- rsp_err  out  1  nonzero syndrome on this read
- rsp_syndrome  out  3  syndrome of this read
- inj_valid  in  1  fault-injection strobe
- inj_addr  in  ADDR_W  injection address
- inj_mask  in  7  XOR mask applied to the stored codeword
- err_count  out  8  corrected-error count; saturates at 255
- scrub_active  out  1  high while a scrub operation is in flight

## Operation
- Codeword cw[6:0]:
  - cw0=d0^d1^d3, cw1=d0^d2^d3, cw2=d0, cw3=d1^d2^d3, cw4=d1, cw5=d2, cw6=d3.
- Syndrome s[2:0]:
  - s0=cw0^cw2^cw4^cw6, s1=cw1^cw2^cw5^cw6, s2=cw3^cw4^cw5^cw6.
  - s≠0 flips cw[s-1]; data = {cw6,cw5,cw4,cw2}.
- No double-error detection. A double error is miscorrected like a single error; this is a known limitation.
- States:
  - IDLE: req_ready=1.
    - Write accept: encode and write to the array at the accept edge; stay in IDLE.
    - Read accept: latch the stored codeword and address; go to CHK.
  - CHK: compute syndrome; register rsp_*.
    - s=0 → IDLE.
    - s≠0 → WB.
  - WB: write the corrected codeword back to the latched address → IDLE.
  - SCRUB_CHK: same as CHK, but for scrub_addr and with no rsp_valid.
    - s≠0 → SCRUB_WB.
    - otherwise → IDLE; scrub_addr increments.
  - SCRUB_WB: write back → IDLE; scrub_addr increments.
- req_ready is 0 in every state other than IDLE.
- err_count increments by 1 on each s≠0 in CHK or SCRUB_CHK and holds at 255.
- Injection: cw ^= inj_mask at inj_addr in any state. It is dropped if the array is written in the same cycle (write or WB wins).
- scrub_addr wraps from 2**ADDR_W-1 to 0.

## Timing
- Reset:
  - state=IDLE.
  - Outputs: req_ready=1 once in IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_syndrome=0; err_count=0; scrub_active=0.
  - All array entries = 7'h00 (valid codeword of data 0); scrub_addr=0; scrub timer=0.
- Write: accepted at edge T; visible to a read accepted at T+1.
- Read accepted at edge T:
  - CHK during T+1; rsp_valid is high for exactly the cycle after edge T+1.
  - req_ready is low for one cycle, or two cycles when WB runs.
- Back-to-back reads with no error: one accept every 2 cycles.
- Reset mid-operation: the in-flight read response is dropped, a pending WB is abandoned, and the array is cleared.
- Reads latch the array value, including any injection applied at an earlier edge. An injection at the accept edge itself is not seen by that read.

## Configuration
- ECC_SCRUB_EN defined:
  - The scrub timer counts IDLE cycles with req_valid=0.
  - At SCRUB_INTERVAL-1 it enters SCRUB_CHK and the timer clears.
  - If req_valid=1 when the timer expires, the request wins and the timer holds until the first IDLE cycle without req_valid.
  - scrub_active=1 in SCRUB_CHK and SCRUB_WB.
- ECC_SCRUB_EN undefined:
  - No scrub states, timer or scrub_addr.
  - scrub_active is tied to 0; SCRUB_INTERVAL is ignored.

## Test plan
- Write addr 3 data 4'hB, stored cw=7'h55; read addr 3 → rsp_rdata=4'hB, rsp_err=0, rsp_syndrome=0, rsp_valid 2 cycles after accept, err_count=0.
- Inject mask 7'h10 at addr 3; read → rsp_rdata=4'hB, rsp_err=1, rsp_syndrome=3'd5, WB cycle seen, err_count=1. Re-read → rsp_err=0.
- Inject mask 7'h01 at addr 0 (data 0), read → rsp_rdata=0, rsp_syndrome=1, err_count increments.
- ECC_SCRUB_EN, SCRUB_INTERVAL=8, no traffic: inject 7'h04 at addr 0 → scrub corrects addr 0 within 10 cycles, err_count=1; subsequent read rsp_err=0.
- Read accepted at T, rst high at T+1 → no rsp_valid; after reset, read addr 3 → rsp_rdata=0, err_count=0.
- Force 300 corrected reads → err_count=255 holds.
